// File: rtl/bcd_down_counter2_if.sv
// Control and display bus of the two-digit BCD countdown timer.
// master drives load/start/pause; slave returns the digits and status pulses.
interface bcd_down_counter2_if;
   logic       load;
   logic [3:0] load_tens;
   logic [3:0] load_ones;
   logic       start;
   logic       pause;
   logic [3:0] count_ones;
   logic [3:0] count_tens;
   logic       running;
   logic       done;
   logic       load_err;

   modport master (
      output load, load_tens, load_ones, start, pause,
      input  count_ones, count_tens, running, done, load_err
   );

   modport slave (
      input  load, load_tens, load_ones, start, pause,
      output count_ones, count_tens, running, done, load_err
   );
endinterface

// File: rtl/bcd_down_counter2.sv
// Two-digit BCD countdown timer (99..00) with preset, pause/resume and optional auto-reload.
// All outputs registered; one step every PRESCALE RUN cycles; no backpressure, inputs act every cycle.
module bcd_down_counter2 #(
   parameter int PRESCALE    = 4,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   bcd_down_counter2_if.slave  bus
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

   state_t        state_q;
   logic [3:0]    ones_q, tens_q;
   logic [3:0]    pre_ones_q, pre_tens_q;
   logic [PW-1:0] presc_q;
   logic          running_q, done_q, load_err_q;

   logic          load_ok, at_zero, pre_zero, presc_wrap, dec_zero;
   logic [3:0]    dec_ones_d, dec_tens_d;

   always_comb begin
      load_ok    = (bus.load_tens <= 4'd9) && (bus.load_ones <= 4'd9);
      at_zero    = (ones_q == 4'd0) && (tens_q == 4'd0);
      pre_zero   = (pre_ones_q == 4'd0) && (pre_tens_q == 4'd0);
      presc_wrap = (presc_q == PW'(PRESCALE - 1));
      dec_ones_d = ones_q - 4'd1;
      dec_tens_d = tens_q;
      // Borrow from tens; never applied at 00, so digits stay within 0..9.
      if (ones_q == 4'd0) begin
         dec_ones_d = 4'd9;
         dec_tens_d = tens_q - 4'd1;
      end
      dec_zero = (dec_ones_d == 4'd0) && (dec_tens_d == 4'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ones_q     <= 4'd0;
         tens_q     <= 4'd0;
         pre_ones_q <= 4'd0;
         pre_tens_q <= 4'd0;
         presc_q    <= '0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
         if (bus.load) begin
            // A rejected load freezes the whole cycle apart from the error pulse.
            if (load_ok) begin
               ones_q     <= bus.load_ones;
               tens_q     <= bus.load_tens;
               pre_ones_q <= bus.load_ones;
               pre_tens_q <= bus.load_tens;
               presc_q    <= '0;
               state_q    <= IDLE;
               running_q  <= 1'b0;
            end else begin
               load_err_q <= 1'b1;
            end
         end else if (bus.pause) begin
            if (state_q == RUN) begin
               state_q   <= PAUSED;
               running_q <= 1'b0;
            end
         end else if (bus.start && state_q != RUN) begin
            case (state_q)
               IDLE: begin
                  if (!at_zero) begin
                     state_q   <= RUN;
                     running_q <= 1'b1;
                     presc_q   <= '0;
                  end
               end
               PAUSED: begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
               EXPIRED: begin
                  ones_q  <= pre_ones_q;
                  tens_q  <= pre_tens_q;
                  presc_q <= '0;
                  if (!pre_zero) begin
                     state_q   <= RUN;
                     running_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (state_q == RUN) begin
            if (presc_wrap) begin
               presc_q <= '0;
               // Sitting at 00 while running only happens in auto-reload mode.
               if (at_zero) begin
                  ones_q <= pre_ones_q;
                  tens_q <= pre_tens_q;
               end else begin
                  ones_q <= dec_ones_d;
                  tens_q <= dec_tens_d;
                  if (dec_zero) begin
                     done_q <= 1'b1;
                     if (!AUTO_RELOAD) begin
                        state_q   <= EXPIRED;
                        running_q <= 1'b0;
                     end
                  end
               end
            end else begin
               presc_q <= presc_q + 1'b1;
            end
         end
      end
   end

   assign bus.count_ones = ones_q;
   assign bus.count_tens = tens_q;
   assign bus.running    = running_q;
   assign bus.done       = done_q;
   assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter2.sv
// Drives three timer variants (stop/reload at PRESCALE 4, stop at PRESCALE 1) with directed then random
// stimulus and compares every output each cycle against an integer-valued reference model.
module tb_bcd_down_counter2;

   localparam int NM = 3;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_EXPIRED = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, ld, st, pz;
   logic [3:0] lt, lo;

   bcd_down_counter2_if if0();
   bcd_down_counter2_if if1();
   bcd_down_counter2_if if2();

   assign if0.load = ld; assign if0.load_tens = lt; assign if0.load_ones = lo; assign if0.start = st; assign if0.pause = pz;
   assign if1.load = ld; assign if1.load_tens = lt; assign if1.load_ones = lo; assign if1.start = st; assign if1.pause = pz;
   assign if2.load = ld; assign if2.load_tens = lt; assign if2.load_ones = lo; assign if2.start = st; assign if2.pause = pz;

   bcd_down_counter2 #(.PRESCALE(4), .AUTO_RELOAD(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   bcd_down_counter2 #(.PRESCALE(4), .AUTO_RELOAD(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   bcd_down_counter2 #(.PRESCALE(1), .AUTO_RELOAD(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

   int m_pres[NM] = '{4, 4, 1};
   bit m_ar[NM]   = '{1'b0, 1'b1, 1'b0};
   int m_val[NM], m_pre[NM], m_st[NM], m_cnt[NM];
   bit m_done[NM], m_err[NM];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Value kept as a plain integer 0..99; digits are derived only for comparison.
   task automatic model_step();
      for (int k = 0; k < NM; k++) begin
         if (rst) begin
            m_val[k] = 0; m_pre[k] = 0; m_st[k] = S_IDLE; m_cnt[k] = 0;
            m_done[k] = 0; m_err[k] = 0;
         end else begin
            m_done[k] = 0;
            m_err[k]  = 0;
            if (ld) begin
               if (lt > 9 || lo > 9) m_err[k] = 1;
               else begin
                  m_val[k] = lt * 10 + lo; m_pre[k] = m_val[k]; m_cnt[k] = 0; m_st[k] = S_IDLE;
               end
            end else if (pz) begin
               if (m_st[k] == S_RUN) m_st[k] = S_PAUSED;
            end else if (st && m_st[k] != S_RUN) begin
               if (m_st[k] == S_IDLE && m_val[k] != 0) begin
                  m_st[k] = S_RUN; m_cnt[k] = 0;
               end else if (m_st[k] == S_PAUSED) begin
                  m_st[k] = S_RUN;
               end else if (m_st[k] == S_EXPIRED) begin
                  m_val[k] = m_pre[k]; m_cnt[k] = 0;
                  if (m_pre[k] != 0) m_st[k] = S_RUN;
               end
            end else if (m_st[k] == S_RUN) begin
               m_cnt[k]++;
               if (m_cnt[k] == m_pres[k]) begin
                  m_cnt[k] = 0;
                  if (m_val[k] == 0) m_val[k] = m_pre[k];
                  else begin
                     m_val[k]--;
                     if (m_val[k] == 0) begin
                        m_done[k] = 1;
                        if (!m_ar[k]) m_st[k] = S_EXPIRED;
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic chk_dut(input string nm, input int k, input logic [3:0] ct, input logic [3:0] co,
                          input logic r, input logic d, input logic e);
      chk_eq({nm, ".tens"}, 32'(ct), 32'(m_val[k] / 10));
      chk_eq({nm, ".ones"}, 32'(co), 32'(m_val[k] % 10));
      chk_eq({nm, ".running"}, 32'(r), 32'(m_st[k] == S_RUN));
      chk_eq({nm, ".done"}, 32'(d), 32'(m_done[k]));
      chk_eq({nm, ".load_err"}, 32'(e), 32'(m_err[k]));
   endtask

   task automatic cyc(input logic r, input logic l, input logic [3:0] t, input logic [3:0] o,
                      input logic s, input logic p);
      rst = r; ld = l; lt = t; lo = o; st = s; pz = p;
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk_dut("d0", 0, if0.count_tens, if0.count_ones, if0.running, if0.done, if0.load_err);
      chk_dut("d1", 1, if1.count_tens, if1.count_ones, if1.running, if1.done, if1.load_err);
      chk_dut("d2", 2, if2.count_tens, if2.count_ones, if2.running, if2.done, if2.load_err);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic load(input logic [3:0] t, input logic [3:0] o);
      cyc(0, 1, t, o, 0, 0);
   endtask

   task automatic start();
      cyc(0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 4'd5, 4'd5, 1, 0);
      idle(2);

      load(1, 2); start(); idle(60);
      start(); idle(4);

      load(4'd10, 3); idle(2); load(0, 5); idle(1);

      load(3, 0); start(); idle(8);
      cyc(0, 0, 0, 0, 0, 1); idle(7);
      start(); idle(10);

      load(2, 0); cyc(0, 0, 0, 0, 1, 1); idle(2);
      start(); idle(2); cyc(0, 0, 0, 0, 1, 1); idle(3);
      load(0, 0); start(); idle(2);

      load(0, 2); start(); idle(30);
      load(0, 1); start(); idle(6);

      load(4, 8); start(); idle(4);
      cyc(1, 0, 0, 0, 0, 0); start(); idle(2);
      load(4, 7); start(); idle(3); load(4, 7); idle(5);

      for (int i = 0; i < 3000; i++) begin
         logic       r, l, s, p;
         logic [3:0] t, o;
         r = ($urandom_range(0, 199) == 0);
         l = ($urandom_range(0, 29) == 0);
         s = ($urandom_range(0, 7) == 0);
         p = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 4) == 0) begin
            t = 4'($urandom_range(0, 15));
            o = 4'($urandom_range(0, 15));
         end else begin
            t = 4'($urandom_range(0, 2));
            o = 4'($urandom_range(0, 9));
         end
         cyc(r, l, t, o, s, p);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_down_counter2.md
Name: bcd_down_counter2

Overview:
- Two-digit BCD down-counter (countdown timer), 99..00.
- Complements the existing up-counting BCD digit pair: software or upstream logic loads a preset, starts it, and receives a terminal-count pulse at 00.
- Drives the same 4-bit-per-digit display path as the up-counter; a shared prescaler sets the count rate.

Parameters:
- PRESCALE, 4, clk cycles per count step (>=1; 1 = step every cycle).
- AUTO_RELOAD, 0, 1 = restart from preset after reaching 00 instead of stopping.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  capture load_tens/load_ones as preset and current value.
- load_tens  input  4  preset tens digit, BCD.
- load_ones  input  4  preset ones digit, BCD.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- count_ones  output  4  current ones digit.
- count_tens  output  4  current tens digit.
- running  output  1  high while in RUN.
- done  output  1  one-cycle pulse when value steps to 00.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst=1 at a clk edge): count_ones=count_tens=0, preset=00, prescaler=0, state IDLE, running=0, done=0, load_err=0. Reset overrides all other inputs, including mid-count.
- States: IDLE, RUN, PAUSED, EXPIRED. running = (state==RUN), registered.
- Priority per cycle: rst > load > pause > start.
- Load, accepted in any state:
  - Both digits <=9: value and preset take the load digits, prescaler=0, state IDLE.
  - Either digit >9: load_err pulses next cycle; value, preset and state are unchanged.
- Start:
  - IDLE, value!=00: go to RUN, prescaler=0.
  - IDLE, value==00: ignored.
  - PAUSED: go to RUN, prescaler keeps its held value.
  - EXPIRED: value=preset, prescaler=0, go to RUN if preset!=00, else stay EXPIRED.
  - RUN: ignored.
- Pause: RUN goes to PAUSED, holding value and prescaler. Ignored in other states. If start and pause are both high, pause wins.
- Prescaler in RUN:
  - Increments each cycle; at PRESCALE-1 it wraps to 0 and a step occurs.
  - The first step follows PRESCALE RUN cycles after entry, so the value changes PRESCALE edges after running rises.
- Step (decrement):
  - ones>0: ones-1.
  - ones==0: ones=9, tens-1.
  - Digits never leave 0..9.
- Step producing 00:
  - done=1 for exactly one cycle, coincident with 00 appearing on the outputs.
  - AUTO_RELOAD=0: state EXPIRED, running=0, value held at 00.
  - AUTO_RELOAD=1: stay in RUN. The next step loads preset instead of decrementing (period = preset+1 steps), with no done on the reload step.
- Preset 01: the first step yields 00 and done.
- Load during RUN aborts the count: no done, state IDLE.
- done and load_err are never asserted in the cycle after reset.

Test Plan:
- PRESCALE=4. rst, load 0x12, start -> running=1 next cycle; digits 1,2 -> 1,1 -> 1,0 -> 0,9 ... -> 0,0, one step every 4 cycles. done pulses once as 00 appears; then running=0, EXPIRED.
- Load tens=0xA, ones=3 -> load_err one-cycle pulse; value and state unchanged. Then load 0x05 -> accepted, load_err=0.
- Count from 0x30, pause for 7 cycles after 2 steps -> value holds 0x28 and prescaler holds; start -> the next step occurs after the remaining prescaler cycles only.
- start and pause high together in IDLE and in RUN -> pause wins: stays IDLE / goes PAUSED. start with value 00 in IDLE -> ignored.
- AUTO_RELOAD=1, preset 0x02 -> sequence 02,01,00(done),02,01,00(done); running stays 1 throughout.
- rst asserted mid-count at 0x47 -> next cycle all outputs 0, state IDLE. start -> ignored (value 00). load 0x47 mid-RUN -> IDLE, no done.
